v_fxp_round_wb: RTL

//  Writeback stage directly downstream of the add/min/max ALU pipeline. Applies RVV fixed-point

---
 rtl/v_fxp_round_wb.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/v_fxp_round_wb.sv
// v_fxp_round_wb: vxrm rounding of averaging-add beats, then a result FIFO toward the VRF write port.
// Define VFXP_ROUND_EN to build the rounding datapath; without it every beat passes bit-exact.
module v_fxp_round_wb #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 32,
  parameter int BE_WIDTH     = DATA_WIDTH/8,
  parameter int FIFO_DEPTH   = 8,
  parameter int AFULL_MARGIN = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_vec,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [BE_WIDTH-1:0]   in_be,
  input  logic                  in_mask,
  input  logic                  in_fxp,
  input  logic [BE_WIDTH-1:0]   in_vd,
  input  logic [BE_WIDTH-1:0]   in_vd1,
  input  logic [1:0]            in_sew,
  input  logic [1:0]            in_vxrm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_vec,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [BE_WIDTH-1:0]   out_be,
  output logic                  out_mask,
  output logic                  out_afull,
  output logic                  err_overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(FIFO_DEPTH - AFULL_MARGIN);

  logic [DATA_WIDTH-1:0] s1_in_vec;

`ifdef VFXP_ROUND_EN
  function automatic logic round_inc(input logic vd, input logic vd1, input logic [1:0] vxrm);
    case (vxrm)
      2'd0:    return vd1;
      2'd1:    return vd1 & vd;
      2'd2:    return 1'b0;
      default: return vd1 & ~vd;
    endcase
  endfunction

  logic [DATA_WIDTH-1:0] sum8, sum16, sum32, sum64, rounded;

  // One adder set per element width; each element adds its own increment so carries never cross lanes.
  always_comb begin
    sum8    = in_vec;
    sum16   = in_vec;
    sum32   = in_vec;
    sum64   = in_vec;
    rounded = in_vec;
    for (int e = 0; e < DATA_WIDTH/8; e++)
      sum8[e*8 +: 8] = in_vec[e*8 +: 8] + {7'd0, round_inc(in_vd[e], in_vd1[e], in_vxrm)};
    for (int e = 0; e < DATA_WIDTH/16; e++)
      sum16[e*16 +: 16] = in_vec[e*16 +: 16] + {15'd0, round_inc(in_vd[e*2], in_vd1[e*2], in_vxrm)};
    for (int e = 0; e < DATA_WIDTH/32; e++)
      sum32[e*32 +: 32] = in_vec[e*32 +: 32] + {31'd0, round_inc(in_vd[e*4], in_vd1[e*4], in_vxrm)};
    for (int e = 0; e < DATA_WIDTH/64; e++)
      sum64[e*64 +: 64] = in_vec[e*64 +: 64] + {63'd0, round_inc(in_vd[e*8], in_vd1[e*8], in_vxrm)};
    case (in_sew)
      2'd0:    rounded = sum8;
      2'd1:    rounded = sum16;
      2'd2:    rounded = sum32;
      default: rounded = sum64;
    endcase
    s1_in_vec = (in_fxp && !in_mask) ? rounded : in_vec;
  end
`else
  logic unused_round;
  assign s1_in_vec    = in_vec;
  assign unused_round = ^{in_vd, in_vd1, in_vxrm, in_sew, in_fxp};
`endif

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_vec;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic [BE_WIDTH-1:0]   s1_be;
  logic                  s1_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_vec   <= '0;
      s1_addr  <= '0;
      s1_be    <= '0;
      s1_mask  <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_vec  <= s1_in_vec;
        s1_addr <= in_addr;
        s1_be   <= in_be;
        s1_mask <= in_mask;
      end
    end
  end

  logic [DATA_WIDTH-1:0] mem_vec  [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
  logic [BE_WIDTH-1:0]   mem_be   [FIFO_DEPTH];
  logic                  mem_mask [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          full, pop, push, head_load, head_from_s1;

  assign full       = (count == DEPTH_C);
  assign out_valid  = (count != '0);
  assign out_afull  = (count >= AFULL_C);
  assign pop        = out_valid & out_ready;
  assign push       = s1_valid & (~full | pop);
  assign rd_ptr_nxt = pop ? rd_ptr + PW'(1) : rd_ptr;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // The next head is the beat being pushed only when it lands in the slot the read pointer moves to.
  assign head_load    = (count_nxt != '0);
  assign head_from_s1 = push && (rd_ptr_nxt == wr_ptr);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_vec[wr_ptr]  <= s1_vec;
      mem_addr[wr_ptr] <= s1_addr;
      mem_be[wr_ptr]   <= s1_be;
      mem_mask[wr_ptr] <= s1_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      err_overflow <= 1'b0;
      out_vec      <= '0;
      out_addr     <= '0;
      out_be       <= '0;
      out_mask     <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      if (s1_valid && full && !pop)
        err_overflow <= 1'b1;
      if (head_load) begin
        out_vec  <= head_from_s1 ? s1_vec  : mem_vec[rd_ptr_nxt];
        out_addr <= head_from_s1 ? s1_addr : mem_addr[rd_ptr_nxt];
        out_be   <= head_from_s1 ? s1_be   : mem_be[rd_ptr_nxt];
        out_mask <= head_from_s1 ? s1_mask : mem_mask[rd_ptr_nxt];
      end
    end
  end

endmodule
